shift_out: RTL and testbench

SHIFT_OUT -- requirements
Module: shift_out

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_out_bit_counter.sv | 39 +++
 rtl/shift_out.sv | 126 ++++++++++++
 tb/tb_shift_out.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serializer and its matching deserializer.
package shift_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/shift_out_bit_counter.sv
// Bit-position counter for shift_out: cleared on load, saturates at COUNT.
module bit_counter #(
  parameter int unsigned COUNT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CntW = $clog2(COUNT + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(COUNT);
  localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

  logic [CntW-1:0] cnt_q = '0;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted while the last data bit is on the wire.
  assign o_tc = (cnt_q == LastCnt);

endmodule

// File: rtl/shift_out.sv
// Parallel-to-serial shifter with valid/ready intake and a downstream hold.
// Define SHIFT_OUT_PARITY_EN to append an even-parity strobe after the data bits.
module shift_out
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_hold,
  output logic             o_en,
  output logic             o_data,
  output logic             o_busy,
  output logic             o_done
);

  state_e           state_q = StIdle;
  state_e           state_d;
  logic [WIDTH-1:0] word_q  = '0;
  logic [WIDTH-1:0] word_d;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic             serial_bit;

`ifdef SHIFT_OUT_PARITY_EN
  logic par_q = 1'b0;
  logic par_d;
`endif

  // The word shifts toward the output end, so the outgoing bit sits at a fixed position.
  assign serial_bit = MSB_FIRST ? word_q[WIDTH-1] : word_q[0];

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    o_en     = 1'b0;
    o_data   = 1'b0;
    o_done   = 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          word_d   = i_data;
          cnt_load = 1'b1;
          state_d  = StShift;
`ifdef SHIFT_OUT_PARITY_EN
          par_d    = 1'b0;
`endif
        end
      end
      StShift: begin
        if (!i_hold) begin
          o_en   = 1'b1;
          o_data = serial_bit;
          cnt_en = 1'b1;
          word_d = MSB_FIRST ? {word_q[WIDTH-2:0], 1'b0} : {1'b0, word_q[WIDTH-1:1]};
`ifdef SHIFT_OUT_PARITY_EN
          par_d  = par_q ^ serial_bit;
          if (cnt_tc) state_d = StParity;
`else
          if (cnt_tc) state_d = StDone;
`endif
        end
      end
`ifdef SHIFT_OUT_PARITY_EN
      StParity: begin
        if (!i_hold) begin
          o_en    = 1'b1;
          o_data  = par_q;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      word_q  <= '0;
`ifdef SHIFT_OUT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
`ifdef SHIFT_OUT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q != StIdle);

  bit_counter #(
    .COUNT (WIDTH)
  ) u_bit_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (cnt_load),
    .i_en   (cnt_en),
    .o_tc   (cnt_tc)
  );

`ifdef FORMAL
  a_en_busy:     assert property (@(posedge i_clk) o_en |-> o_busy);
  a_ready_busy:  assert property (@(posedge i_clk) !(o_ready && o_busy));
  a_done_single: assert property (@(posedge i_clk) o_done |=> !o_done);
`endif

endmodule

// File: tb/tb_shift_out.sv
// Directed bench for shift_out: an LSB-first and an MSB-first instance share stimulus.
module tb_shift_out;

`ifdef SHIFT_OUT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NCyc = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       hold = 1'b0;

  logic rdy_l, en_l, dat_l, busy_l, done_l;
  logic rdy_m, en_m, dat_m, busy_m, done_m;

  int checks = 0;
  int errors = 0;

  logic en_a   [NCyc];
  logic dat_a  [NCyc];
  logic done_a [NCyc];
  logic rdy_a  [NCyc];
  logic busy_a [NCyc];
  logic lsb_bits [NCyc];
  logic msb_bits [NCyc];
  int   lsb_n;
  int   msb_n;

  // Downstream deserializer chained to the LSB-first instance; keeps the first 8 strobes.
  logic [7:0] des_sr  = 8'h00;
  int         des_cnt = 0;

  always #5 clk = ~clk;

  shift_out #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk (clk), .i_rst (rst), .i_valid (valid), .i_data (data_in), .o_ready (rdy_l),
    .i_hold (hold), .o_en (en_l), .o_data (dat_l), .o_busy (busy_l), .o_done (done_l)
  );

  shift_out #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk (clk), .i_rst (rst), .i_valid (valid), .i_data (data_in), .o_ready (rdy_m),
    .i_hold (hold), .o_en (en_m), .o_data (dat_m), .o_busy (busy_m), .o_done (done_m)
  );

  always @(posedge clk) begin
    if (rst) begin
      des_sr  <= 8'h00;
      des_cnt <= 0;
    end else if (en_l && des_cnt < 8) begin
      des_sr  <= {dat_l, des_sr[7:1]};
      des_cnt <= des_cnt + 1;
    end
  end

  // Handshake at cycle 0; entry k holds outputs seen between edges k and k+1.
  task automatic capture(input logic [7:0] word, input logic [15:0] hold_mask,
                         input int rst_cyc, input logic [15:0] valid_mask);
    lsb_n = 0;
    msb_n = 0;
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NCyc; k++) begin
      if (k == 0) begin
        valid = 1'b1; data_in = word;
      end else begin
        valid = valid_mask[k]; data_in = 8'h3C;
      end
      hold = hold_mask[k];
      rst  = (k == rst_cyc);
      #1;
      en_a[k] = en_l; dat_a[k] = dat_l; done_a[k] = done_l;
      rdy_a[k] = rdy_l; busy_a[k] = busy_l;
      if (en_l) begin lsb_bits[lsb_n] = dat_l; lsb_n++; end
      if (en_m) begin msb_bits[msb_n] = dat_m; msb_n++; end
      @(posedge clk); #1;
    end
    valid = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy_l, en_l, dat_l, busy_l, done_l} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_lsb got %b want 10000", {rdy_l, en_l, dat_l, busy_l, done_l});
    end
    checks++;
    if ({rdy_m, en_m, dat_m, busy_m, done_m} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_msb got %b want 10000", {rdy_m, en_m, dat_m, busy_m, done_m});
    end
  endtask

  task automatic test_lsb_a5();
    logic [7:0] exp_w;
    exp_w = 8'hA5;
    capture(8'hA5, 16'h0000, -1, 16'h0000);
    checks++;
    if (rdy_a[0] !== 1'b1 || en_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5_cycle0 got rdy=%b en=%b want rdy=1 en=0", rdy_a[0], en_a[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (en_a[k] !== 1'b1 || dat_a[k] !== exp_w[k-1]) begin
        errors++;
        $display("FAIL a5_bit%0d got en=%b d=%b want en=1 d=%b", k - 1, en_a[k], dat_a[k],
                 exp_w[k-1]);
      end
    end
    checks++;
    if (busy_a[1] !== 1'b1 || rdy_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy got busy=%b rdy=%b want busy=1 rdy=0", busy_a[1], rdy_a[1]);
    end
    for (int k = 0; k < NCyc; k++) begin
      checks++;
      if (done_a[k] !== (k == 9 + P)) begin
        errors++;
        $display("FAIL a5_done_c%0d got %b want %b", k, done_a[k], (k == 9 + P));
      end
    end
    checks++;
    if (rdy_a[10 + P] !== 1'b1 || en_a[9 + P] !== 1'b0 || dat_a[9 + P] !== 1'b0) begin
      errors++;
      $display("FAIL a5_tail got rdy=%b en=%b d=%b want 1 0 0", rdy_a[10 + P], en_a[9 + P],
               dat_a[9 + P]);
    end
  endtask

  task automatic test_msb_80();
    logic [7:0] got;
    capture(8'h80, 16'h0000, -1, 16'h0000);
    got = 8'h00;
    for (int i = 0; i < 8; i++) got[7-i] = msb_bits[i];
    checks++;
    if (msb_n !== 8 + P || got !== 8'h80) begin
      errors++;
      $display("FAIL msb_80 got n=%0d bits=%h want n=%0d bits=80", msb_n, got, 8 + P);
    end
    got = 8'h00;
    for (int i = 0; i < 8; i++) got[i] = lsb_bits[i];
    checks++;
    if (got !== 8'h80) begin
      errors++;
      $display("FAIL lsb_80 got %h want 80", got);
    end
  endtask

  task automatic test_hold();
    logic [7:0] got;
    logic       exp_en;
    capture(8'hA5, 16'h0038, -1, 16'h0000);
    for (int k = 1; k <= 12 + P; k++) begin
      exp_en = (k <= 11 + P) && !(k >= 3 && k <= 5);
      checks++;
      if (en_a[k] !== exp_en) begin
        errors++;
        $display("FAIL hold_en_c%0d got %b want %b", k, en_a[k], exp_en);
      end
    end
    got = 8'h00;
    for (int i = 0; i < 8; i++) got[i] = lsb_bits[i];
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL hold_bits got %h want a5", got);
    end
    checks++;
    if (done_a[12 + P] !== 1'b1 || done_a[9 + P] !== 1'b0) begin
      errors++;
      $display("FAIL hold_done got %b/%b want 1/0", done_a[12 + P], done_a[9 + P]);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] got;
    capture(8'hFF, 16'h0000, -1, 16'h01FE);
    got = 8'h00;
    for (int i = 0; i < 8; i++) got[i] = lsb_bits[i];
    checks++;
    if (got !== 8'hFF || lsb_n !== 8 + P) begin
      errors++;
      $display("FAIL ignore_bits got %h n=%0d want ff n=%0d", got, lsb_n, 8 + P);
    end
    checks++;
    if (done_a[9 + P] !== 1'b1 || busy_a[11 + P] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_tail got done=%b busy=%b want 1 0", done_a[9 + P], busy_a[11 + P]);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    capture(8'hFF, 16'h0000, 4, 16'h0000);
    checks++;
    if (en_a[5] !== 1'b0 || rdy_a[5] !== 1'b1 || dat_a[5] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got en=%b rdy=%b d=%b want 0 1 0", en_a[5], rdy_a[5], dat_a[5]);
    end
    ndone = 0;
    for (int k = 0; k < NCyc; k++) if (done_a[k]) ndone++;
    checks++;
    if (ndone !== 0 || lsb_n !== 4) begin
      errors++;
      $display("FAIL rst_mid_done got done=%0d strobes=%0d want 0 4", ndone, lsb_n);
    end
  endtask

`ifdef SHIFT_OUT_PARITY_EN
  task automatic test_parity();
    capture(8'h07, 16'h0000, -1, 16'h0000);
    checks++;
    if (en_a[9] !== 1'b1 || dat_a[9] !== 1'b1 || done_a[10] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07 got en=%b d=%b done=%b want 1 1 1", en_a[9], dat_a[9],
               done_a[10]);
    end
    capture(8'h03, 16'h0000, -1, 16'h0000);
    checks++;
    if (en_a[9] !== 1'b1 || dat_a[9] !== 1'b0 || done_a[10] !== 1'b1) begin
      errors++;
      $display("FAIL parity_03 got en=%b d=%b done=%b want 1 0 1", en_a[9], dat_a[9],
               done_a[10]);
    end
  endtask
`endif

  task automatic test_chain();
    capture(8'h5A, 16'h0000, -1, 16'h0000);
    checks++;
    if (des_sr !== 8'h5A || des_cnt !== 8) begin
      errors++;
      $display("FAIL chain got %h cnt=%0d want 5a cnt=8", des_sr, des_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_a5();
    test_msb_80();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
`ifdef SHIFT_OUT_PARITY_EN
    test_parity();
`endif
    test_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
